display_scroll_ctrl: RTL and testbench

Sequencing controller for the four-digit LED driver. It holds a 16-entry message buffer of 4-bit digit codes and presents a sliding four-character window on `char3`..`char0`, one code per anode position. A start/stop/pause control FSM and a programmable scroll-rate divider advance the window, with wrap-around at the end of the message. It sits between the board control logic, which writes the message and issues commands, and `FourDigitLEDdriver`, which multiplexes the window onto `an3`..`an0` and `led_a`..`led_g`.

---
 rtl/display_scroll_ctrl.sv | 127 ++++++++++++
 tb/tb_display_scroll_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scroll_ctrl.sv
// Scroll sequencer for the four-digit LED driver: message buffer, start/stop/pause FSM and
// rate divider that slide a four-character window across the message with wrap-around.
module display_scroll_ctrl #(
    parameter int unsigned MSG_LEN    = 16,
    parameter int unsigned SCROLL_DIV = 20_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       wr_ready,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    output logic [3:0] char3,
    output logic [3:0] char2,
    output logic [3:0] char1,
    output logic [3:0] char0,
    output logic       upd,
    output logic       wrap,
    output logic       busy
);

    localparam int unsigned PtrW = $clog2(MSG_LEN);
    localparam int unsigned DivW = $clog2(SCROLL_DIV);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold
    } state_e;

    state_e          state_q;
    logic [3:0]      mem_q [MSG_LEN];
    logic [PtrW-1:0] ptr_q;
    logic [DivW-1:0] div_q;
    logic [3:0]      char3_q, char2_q, char1_q, char0_q;
    logic            upd_q, wrap_q;

    logic [PtrW-1:0] ptr_inc;
    logic            tick;
    logic            wr_accept;

    assign ptr_inc   = ptr_q + PtrW'(1);
    assign tick      = (div_q == DivW'(SCROLL_DIV - 1));
    assign wr_accept = wr_en && (state_q == StIdle);

    // Message buffer; reads for window loads see the pre-write contents on a shared edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MSG_LEN; i++) begin
                mem_q[i] <= 4'h0;
            end
        end else if (wr_accept) begin
            mem_q[PtrW'(wr_addr)] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            div_q   <= '0;
            char3_q <= 4'h0;
            char2_q <= 4'h0;
            char1_q <= 4'h0;
            char0_q <= 4'h0;
            upd_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            upd_q  <= 1'b0;
            wrap_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && !stop) begin
                        state_q <= StRun;
                        ptr_q   <= '0;
                        div_q   <= '0;
                        char3_q <= mem_q[0];
                        char2_q <= mem_q[1];
                        char1_q <= mem_q[2];
                        char0_q <= mem_q[3];
                        upd_q   <= 1'b1;
                    end
                end
                StRun, StHold: begin
                    if (stop) begin
                        state_q <= StIdle;
                        ptr_q   <= '0;
                        div_q   <= '0;
                    end else if (pause) begin
                        state_q <= StHold;
                    end else begin
                        // Leaving HOLD counts on the same edge so each HOLD cycle costs one.
                        state_q <= StRun;
                        if (tick) begin
                            div_q   <= '0;
                            ptr_q   <= ptr_inc;
                            char3_q <= mem_q[ptr_inc];
                            char2_q <= mem_q[ptr_inc + PtrW'(1)];
                            char1_q <= mem_q[ptr_inc + PtrW'(2)];
                            char0_q <= mem_q[ptr_inc + PtrW'(3)];
                            upd_q   <= 1'b1;
                            wrap_q  <= (ptr_q == PtrW'(MSG_LEN - 1));
                        end else begin
                            div_q <= div_q + DivW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign char3    = char3_q;
    assign char2    = char2_q;
    assign char1    = char1_q;
    assign char0    = char0_q;
    assign upd      = upd_q;
    assign wrap     = wrap_q;
    assign busy     = (state_q != StIdle);
    assign wr_ready = (state_q == StIdle);

endmodule

// File: tb/tb_display_scroll_ctrl.sv
// Directed bench for display_scroll_ctrl with a short scroll divider and hand-computed windows.
module tb_display_scroll_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ready;
    logic       start;
    logic       stop;
    logic       pause;
    logic [3:0] char3, char2, char1, char0;
    logic       upd;
    logic       wrap;
    logic       busy;
    logic [15:0] win;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    assign win = {char3, char2, char1, char0};

    display_scroll_ctrl #(
        .MSG_LEN    (16),
        .SCROLL_DIV (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .char3    (char3),
        .char2    (char2),
        .char1    (char1),
        .char0    (char0),
        .upd      (upd),
        .wrap     (wrap),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".win"}, win, 16'h0000);
        check({tag, ".upd"}, 16'(upd), 16'h0);
        check({tag, ".wrap"}, 16'(wrap), 16'h0);
        check({tag, ".busy"}, 16'(busy), 16'h0);
        check({tag, ".wr_ready"}, 16'(wr_ready), 16'h1);
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 4'h0;
        wr_data = 4'h0;
        start   = 1'b0;
        stop    = 1'b0;
        pause   = 1'b0;

        #250;
        check_idle_zero("rst_during");
        #250;
        reset = 1'b0;
        #1;
        check_idle_zero("rst_release");
        cycles(1);
        check_idle_zero("rst_after_edge");

        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = 4'(i);
            cycles(1);
        end
        wr_en = 1'b0;
        check("write_no_window_change", win, 16'h0000);

        // E0
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        check("start.win", win, 16'h0123);
        check("start.upd", 16'(upd), 16'h1);
        check("start.busy", 16'(busy), 16'h1);
        check("start.wr_ready", 16'(wr_ready), 16'h0);
        cycles(1);
        check("e1.upd", 16'(upd), 16'h0);
        cycles(3);
        check("tick1.win", win, 16'h1234);
        check("tick1.upd", 16'(upd), 16'h1);
        cycles(48);
        check("ptr13.win", win, 16'hDEF0);
        check("ptr13.upd", 16'(upd), 16'h1);
        check("ptr13.wrap", 16'(wrap), 16'h0);
        cycles(12);
        check("wrap.win", win, 16'h0123);
        check("wrap.wrap", 16'(wrap), 16'h1);
        check("wrap.upd", 16'(upd), 16'h1);
        cycles(1);
        check("wrap_end.wrap", 16'(wrap), 16'h0);
        check("wrap_end.upd", 16'(upd), 16'h0);

        // E0+65, div=1: unpaused tick would land at E0+68
        pause = 1'b1;
        cycles(3);
        pause = 1'b0;
        check("hold.win", win, 16'h0123);
        check("hold.upd", 16'(upd), 16'h0);
        check("hold.busy", 16'(busy), 16'h1);
        cycles(2);
        check("hold_late.win", win, 16'h0123);
        check("hold_late.upd", 16'(upd), 16'h0);
        cycles(1);
        check("resume_tick.win", win, 16'h1234);
        check("resume_tick.upd", 16'(upd), 16'h1);

        wr_en   = 1'b1;
        wr_addr = 4'h0;
        wr_data = 4'h9;
        cycles(1);
        wr_en = 1'b0;
        check("lock.wr_ready", 16'(wr_ready), 16'h0);
        stop = 1'b1;
        cycles(1);
        stop = 1'b0;
        check("stop.busy", 16'(busy), 16'h0);
        check("stop.wr_ready", 16'(wr_ready), 16'h1);
        check("stop.win", win, 16'h1234);
        check("stop.upd", 16'(upd), 16'h0);
        cycles(5);
        check("idle_hold.win", win, 16'h1234);

        start = 1'b1;
        cycles(1);
        start = 1'b0;
        check("lockout_restart.win", win, 16'h0123);

        stop  = 1'b1;
        start = 1'b1;
        cycles(1);
        check("prio_run.busy", 16'(busy), 16'h0);
        check("prio_run.upd", 16'(upd), 16'h0);
        check("prio_run.win", win, 16'h0123);
        cycles(1);
        check("prio_idle.busy", 16'(busy), 16'h0);
        check("prio_idle.upd", 16'(upd), 16'h0);
        stop = 1'b0;

        // write and start on one edge: window uses pre-write data
        wr_en   = 1'b1;
        wr_addr = 4'h0;
        wr_data = 4'h9;
        cycles(1);
        start = 1'b0;
        wr_en = 1'b0;
        check("wr_start.win", win, 16'h0123);
        check("wr_start.upd", 16'(upd), 16'h1);
        stop = 1'b1;
        cycles(1);
        stop  = 1'b0;
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        check("written.win", win, 16'h9123);
        check("written.upd", 16'(upd), 16'h1);

        cycles(3);
        check("pre_rst.win", win, 16'h9123);
        #4;
        reset = 1'b1;
        #1;
        check_idle_zero("async_rst");
        cycles(2);
        #4;
        reset = 1'b0;
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        check("post_rst_start.busy", 16'(busy), 16'h1);
        check("post_rst_start.upd", 16'(upd), 16'h1);
        check("post_rst_start.win", win, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
